// File: rtl/divider_arbiter.sv
// divider_arbiter: shares one iterative divider between NUM_REQ requesters.
// Requests are picked round-robin, and only one division is in flight at a time.
// A zero divisor is answered at once with an error and is never sent to the divider.
// A divider that never answers is abandoned after TIMEOUT_CYC cycles and also gives an error.
// Ports:
//   clk_in, rst_in               clock, synchronous active-low reset
//   req_valid_in/req_ready_out   per-requester handshake (ready is combinational, IDLE only)
//   dividend_in/divisor_in       flattened operands, requester i at [i*WIDTH +: WIDTH]
//   div_*_out / div_*_in         interface to the shared divider
//   rsp_*_out                    one-cycle tagged response
//   busy_out                     transaction in progress
module divider_arbiter #(
   parameter int unsigned NUM_REQ     = 2,
   parameter int unsigned WIDTH       = 32,
   parameter int unsigned TIMEOUT_CYC = 64
) (
   input  logic                         clk_in,
   input  logic                         rst_in,
   input  logic [NUM_REQ-1:0]           req_valid_in,
   output logic [NUM_REQ-1:0]           req_ready_out,
   input  logic [NUM_REQ*WIDTH-1:0]     dividend_in,
   input  logic [NUM_REQ*WIDTH-1:0]     divisor_in,
   output logic [WIDTH-1:0]             div_dividend_out,
   output logic [WIDTH-1:0]             div_divisor_out,
   output logic                         div_valid_out,
   input  logic [WIDTH-1:0]             div_quotient_in,
   input  logic                         div_valid_in,
   output logic                         rsp_valid_out,
   output logic [$clog2(NUM_REQ)-1:0]   rsp_id_out,
   output logic [WIDTH-1:0]             rsp_quotient_out,
   output logic                         rsp_err_out,
   output logic                         busy_out
);

   localparam int unsigned ID_W = $clog2(NUM_REQ);
   localparam int unsigned TM_W = $clog2(TIMEOUT_CYC);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t              state;
   logic [ID_W-1:0]     last_grant;
   logic [TM_W-1:0]     timer;

   logic [2*NUM_REQ-1:0] req_dbl;
   logic [NUM_REQ-1:0]   req_rot;
   int unsigned          start_idx;
   int unsigned          offset;
   int unsigned          sum_idx;
   logic                 grant_found;
   logic [ID_W-1:0]      grant_idx;
   logic [WIDTH-1:0]     sel_dividend;
   logic [WIDTH-1:0]     sel_divisor;

   // Round-robin pick: rotate requests so the slot after last_grant sits at bit 0,
   // take the lowest set bit, then rotate the index back.
   always_comb begin
      start_idx = 32'(last_grant) + 32'd1;
      req_dbl   = {req_valid_in, req_valid_in};
      req_rot   = NUM_REQ'(req_dbl >> start_idx);
      offset    = 32'd0;
      for (int i = int'(NUM_REQ) - 1; i >= 0; i--) begin
         if (req_rot[i]) offset = 32'(i);
      end
      sum_idx = start_idx + offset;
      if (sum_idx >= NUM_REQ) sum_idx = sum_idx - NUM_REQ;
      grant_found  = |req_valid_in;
      grant_idx    = ID_W'(sum_idx);
      sel_dividend = dividend_in[32'(grant_idx)*WIDTH +: WIDTH];
      sel_divisor  = divisor_in[32'(grant_idx)*WIDTH +: WIDTH];
      req_ready_out = '0;
      if (state == S_IDLE && grant_found) req_ready_out[grant_idx] = 1'b1;
   end

   // Transaction FSM with registered outputs.
   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state            <= S_IDLE;
         last_grant       <= ID_W'(NUM_REQ - 1);
         timer            <= '0;
         div_dividend_out <= '0;
         div_divisor_out  <= '0;
         div_valid_out    <= 1'b0;
         rsp_valid_out    <= 1'b0;
         rsp_id_out       <= '0;
         rsp_quotient_out <= '0;
         rsp_err_out      <= 1'b0;
         busy_out         <= 1'b0;
      end else begin
         div_valid_out <= 1'b0;
         rsp_valid_out <= 1'b0;
         case (state)
            S_IDLE: begin
               if (grant_found) begin
                  last_grant       <= grant_idx;
                  rsp_id_out       <= grant_idx;
                  div_dividend_out <= sel_dividend;
                  div_divisor_out  <= sel_divisor;
                  busy_out         <= 1'b1;
                  if (sel_divisor == '0) begin
                     state            <= S_RESP;
                     rsp_valid_out    <= 1'b1;
                     rsp_quotient_out <= '1;
                     rsp_err_out      <= 1'b1;
                  end else begin
                     state         <= S_ISSUE;
                     div_valid_out <= 1'b1;
                  end
               end
            end
            S_ISSUE: begin
               state <= S_WAIT;
               timer <= '0;
            end
            S_WAIT: begin
               // A result arriving on the timeout edge still wins.
               if (div_valid_in) begin
                  state            <= S_RESP;
                  rsp_valid_out    <= 1'b1;
                  rsp_quotient_out <= div_quotient_in;
                  rsp_err_out      <= 1'b0;
               end else if (timer + TM_W'(1) == TM_W'(TIMEOUT_CYC - 1)) begin
                  state            <= S_RESP;
                  rsp_valid_out    <= 1'b1;
                  rsp_quotient_out <= '1;
                  rsp_err_out      <= 1'b1;
               end else begin
                  timer <= timer + TM_W'(1);
               end
            end
            S_RESP: begin
               state    <= S_IDLE;
               busy_out <= 1'b0;
            end
            default: begin
               state    <= S_IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_divider_arbiter.sv
// Bench for divider_arbiter: directed requests, a behavioural divider with
// programmable answer delay, and a scoreboard monitor checking every response.
module tb_divider_arbiter;

   localparam int unsigned NR = 2;
   localparam int unsigned W  = 32;

   logic              clk_in = 1'b0;
   logic              rst_in = 1'b0;
   logic [NR-1:0]     req_valid_in = '0;
   logic [NR-1:0]     req_ready_out;
   logic [NR*W-1:0]   dividend_in = '0;
   logic [NR*W-1:0]   divisor_in = '0;
   logic [W-1:0]      div_dividend_out;
   logic [W-1:0]      div_divisor_out;
   logic              div_valid_out;
   logic [W-1:0]      div_quotient_in;
   logic              div_valid_in;
   logic              rsp_valid_out;
   logic [0:0]        rsp_id_out;
   logic [W-1:0]      rsp_quotient_out;
   logic              rsp_err_out;
   logic              busy_out;

   divider_arbiter #(.NUM_REQ(NR), .WIDTH(W), .TIMEOUT_CYC(64)) dut (
      .clk_in           (clk_in),
      .rst_in           (rst_in),
      .req_valid_in     (req_valid_in),
      .req_ready_out    (req_ready_out),
      .dividend_in      (dividend_in),
      .divisor_in       (divisor_in),
      .div_dividend_out (div_dividend_out),
      .div_divisor_out  (div_divisor_out),
      .div_valid_out    (div_valid_out),
      .div_quotient_in  (div_quotient_in),
      .div_valid_in     (div_valid_in),
      .rsp_valid_out    (rsp_valid_out),
      .rsp_id_out       (rsp_id_out),
      .rsp_quotient_out (rsp_quotient_out),
      .rsp_err_out      (rsp_err_out),
      .busy_out         (busy_out)
   );

   always #5 clk_in = ~clk_in;

   typedef struct packed {
      logic [7:0]  id;
      logic [31:0] q;
      logic        err;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   start_cnt = 0;
   int   start_cyc = 0;
   int   rsp_count = 0;
   int   rsp_cyc = 0;
   logic rsp_busy = 1'b0;
   int   resp_k = 0;

   always @(posedge clk_in) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Behavioural divider: answers resp_k cycles after each start pulse (0 = never).
   initial begin
      int          k;
      logic [31:0] q;
      div_valid_in    = 1'b0;
      div_quotient_in = '0;
      forever begin
         @(negedge clk_in);
         if (div_valid_out) begin
            start_cnt++;
            start_cyc = cyc;
            k = resp_k;
            q = (div_divisor_out != 0) ? div_dividend_out / div_divisor_out : '1;
            if (k > 0) begin
               repeat (k) @(posedge clk_in);
               #1;
               div_valid_in    = 1'b1;
               div_quotient_in = q;
               @(posedge clk_in);
               #1;
               div_valid_in    = 1'b0;
               div_quotient_in = '0;
            end
         end
      end
   end

   // Scoreboard monitor.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk_in);
         if (rsp_valid_out) begin
            rsp_count++;
            rsp_cyc  = cyc;
            rsp_busy = busy_out;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL rsp_unexpected actual id=%0d q=%0h err=%0b expected none",
                        rsp_id_out, rsp_quotient_out, rsp_err_out);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_id_q_err", 64'({8'(rsp_id_out), rsp_quotient_out, rsp_err_out}),
                   64'({e.id, e.q, e.err}));
            end
         end
      end
   end

   task automatic do_reset();
      rst_in = 1'b0;
      repeat (2) @(posedge clk_in);
      #1;
      rst_in = 1'b1;
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_ctrl"}, 64'({div_valid_out, rsp_valid_out, busy_out, rsp_err_out, rsp_id_out}), 64'd0);
      chk({tag, "_ops"}, {div_dividend_out, div_divisor_out}, 64'd0);
      chk({tag, "_quot"}, 64'(rsp_quotient_out), 64'd0);
      chk({tag, "_ready"}, 64'(req_ready_out), 64'd0);
   endtask

   // Raise one request, hold until accepted, drop it the cycle after the accept edge.
   task automatic issue(input int id, input logic [31:0] dvd, input logic [31:0] dvs,
                        output int acc_cyc);
      bit got = 1'b0;
      dividend_in[id*W +: W] = dvd;
      divisor_in[id*W +: W]  = dvs;
      req_valid_in[id]       = 1'b1;
      acc_cyc = -1;
      for (int n = 0; n < 200; n++) begin
         #1;
         if (req_ready_out[id]) begin
            got = 1'b1;
            break;
         end
         @(posedge clk_in);
      end
      chk("accept_seen", 64'(got), 64'd1);
      acc_cyc = cyc;
      @(posedge clk_in);
      #1;
      req_valid_in[id] = 1'b0;
   endtask

   task automatic wait_rsp(input int target);
      for (int n = 0; n < 300 && rsp_count < target; n++) @(posedge clk_in);
      #1;
      chk("rsp_arrived", 64'(rsp_count), 64'(target));
   endtask

   initial begin
      int acc;
      int base;
      int s0;
      int grants;

      // 1: reset state, then 100/7 with a 3-cycle divider.
      do_reset();
      check_reset_outputs("reset");
      resp_k = 3;
      exp_q.push_back('{id: 8'd0, q: 32'd14, err: 1'b0});
      s0 = start_cnt;
      issue(0, 32'd100, 32'd7, acc);
      wait_rsp(1);
      chk("t1_start_lat", 64'(start_cyc), 64'(acc + 1));
      chk("t1_start_cnt", 64'(start_cnt), 64'(s0 + 1));
      chk("t1_rsp_lat", 64'(rsp_cyc), 64'(start_cyc + 4));
      chk("t1_busy_in_rsp", 64'(rsp_busy), 64'd1);
      chk("t1_busy_after", 64'(busy_out), 64'd0);

      // 2: both requesters held from reset, grants must alternate 0,1,0,1.
      do_reset();
      resp_k = 1;
      dividend_in = {32'd90, 32'd20};
      divisor_in  = {32'd9, 32'd4};
      base = rsp_count;
      exp_q.push_back('{id: 8'd0, q: 32'd5,  err: 1'b0});
      exp_q.push_back('{id: 8'd1, q: 32'd10, err: 1'b0});
      exp_q.push_back('{id: 8'd0, q: 32'd5,  err: 1'b0});
      exp_q.push_back('{id: 8'd1, q: 32'd10, err: 1'b0});
      req_valid_in = 2'b11;
      grants = 0;
      for (int n = 0; n < 400 && grants < 4; n++) begin
         #1;
         if (req_ready_out != '0) begin
            chk("t2_grant_order", 64'(req_ready_out), (grants % 2 == 0) ? 64'd1 : 64'd2);
            grants++;
         end
         @(posedge clk_in);
      end
      #1;
      req_valid_in = 2'b00;
      chk("t2_grant_count", 64'(grants), 64'd4);
      wait_rsp(base + 4);

      // 3: zero divisor on req1 answers next cycle without touching the divider.
      base = rsp_count;
      s0 = start_cnt;
      exp_q.push_back('{id: 8'd1, q: 32'hFFFF_FFFF, err: 1'b1});
      issue(1, 32'd55, 32'd0, acc);
      wait_rsp(base + 1);
      chk("t3_rsp_lat", 64'(rsp_cyc), 64'(acc + 1));
      chk("t3_no_start", 64'(start_cnt), 64'(s0));

      // 4: divider answers too late, timeout fires, the late answer is ignored.
      resp_k = 70;
      base = rsp_count;
      exp_q.push_back('{id: 8'd0, q: 32'hFFFF_FFFF, err: 1'b1});
      issue(0, 32'd100, 32'd5, acc);
      wait_rsp(base + 1);
      chk("t4_timeout_lat", 64'(rsp_cyc), 64'(start_cyc + 64));
      repeat (20) @(posedge clk_in);
      #1;
      chk("t4_late_ignored", 64'(rsp_count), 64'(base + 1));
      chk("t4_idle", 64'(busy_out), 64'd0);

      // 5: reset pulse during WAIT drops the transaction; req0 wins afterwards.
      resp_k = 10;
      base = rsp_count;
      issue(0, 32'd30, 32'd3, acc);
      repeat (3) @(posedge clk_in);
      #1;
      rst_in = 1'b0;
      @(posedge clk_in);
      #1;
      rst_in = 1'b1;
      check_reset_outputs("t5_midreset");
      repeat (15) @(posedge clk_in);
      #1;
      chk("t5_no_rsp", 64'(rsp_count), 64'(base));
      resp_k = 2;
      dividend_in = {32'd77, 32'd40};
      divisor_in  = {32'd7, 32'd8};
      exp_q.push_back('{id: 8'd0, q: 32'd5, err: 1'b0});
      req_valid_in = 2'b11;
      #1;
      chk("t5_req0_first", 64'(req_ready_out), 64'd1);
      @(posedge clk_in);
      #1;
      req_valid_in = 2'b00;
      wait_rsp(base + 1);

      // 6: answer arrives on the timeout edge, the result wins.
      resp_k = 63;
      base = rsp_count;
      exp_q.push_back('{id: 8'd0, q: 32'd100, err: 1'b0});
      issue(0, 32'd1000, 32'd10, acc);
      wait_rsp(base + 1);
      chk("t6_rsp_lat", 64'(rsp_cyc), 64'(start_cyc + 64));

      repeat (5) @(posedge clk_in);
      #1;
      chk("sb_drained", 64'(exp_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
